// File: rtl/fp_minmax_tracker.sv
// Streaming IEEE-754 single-precision min/max reducer: folds each accepted beat into
// running extremes and presents min, max, beat count and a NaN flag after the last beat.
module fp_minmax_tracker #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t             r_state;
    logic [31:0]        r_min;
    logic [31:0]        r_max;
    logic [CNT_W-1:0]   r_count;
    logic               r_nan;
    logic               r_have_ord;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_first;
    logic               w_is_nan;
    logic [31:0]        w_canon;
    logic [31:0]        w_base_min;
    logic [31:0]        w_base_max;
    logic [CNT_W-1:0]   w_base_count;
    logic               w_base_nan;
    logic               w_base_have;
    logic [31:0]        w_next_min;
    logic [31:0]        w_next_max;
    logic [CNT_W-1:0]   w_next_count;
    logic               w_next_nan;
    logic               w_next_have;

    // Monotonic unsigned key: negative values are bit-inverted, positives get the sign bit set.
    function automatic logic [31:0] f_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    assign in_ready  = ~rst & (r_state != S_HOLD);
    assign w_accept  = in_valid & in_ready;
    assign w_first   = (r_state == S_IDLE);
    assign w_is_nan  = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    assign w_canon   = (in_data == 32'h8000_0000) ? 32'h0000_0000 : in_data;

    // The first beat of a packet folds into a freshly cleared accumulator set.
    assign w_base_min   = w_first ? QNAN : r_min;
    assign w_base_max   = w_first ? QNAN : r_max;
    assign w_base_count = w_first ? '0   : r_count;
    assign w_base_nan   = w_first ? 1'b0 : r_nan;
    assign w_base_have  = w_first ? 1'b0 : r_have_ord;

    always_comb begin
        w_next_min   = w_base_min;
        w_next_max   = w_base_max;
        w_next_have  = w_base_have;
        w_next_nan   = w_base_nan | w_is_nan;
        w_next_count = (&w_base_count) ? w_base_count : w_base_count + CNT_W'(1);
        if (!w_is_nan) begin
            if (!w_base_have) begin
                w_next_min  = w_canon;
                w_next_max  = w_canon;
                w_next_have = 1'b1;
            end else begin
                if (f_key(w_canon) < f_key(w_base_min)) w_next_min = w_canon;
                if (f_key(w_canon) > f_key(w_base_max)) w_next_max = w_canon;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_min       <= QNAN;
            r_max       <= QNAN;
            r_count     <= '0;
            r_nan       <= 1'b0;
            r_have_ord  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_min       <= w_next_min;
            r_max       <= w_next_max;
            r_count     <= w_next_count;
            r_nan       <= w_next_nan;
            r_have_ord  <= w_next_have;
            r_state     <= in_last ? S_HOLD : S_ACC;
            r_out_valid <= in_last;
        end else if ((r_state == S_HOLD) && out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign out_count = r_count;
    assign out_nan   = r_nan;

endmodule

// File: doc/fp_minmax_tracker.md
Name: fp_minmax_tracker

Overview:
- Streaming IEEE-754 single-precision min/max reducer. It is the consumer-side counterpart of the ALU compare path.
- Accepts a packet of 32-bit floats over a valid/ready stream and orders each beat against running extremes with an internal sign-magnitude comparator.
- After the beat flagged last, presents min, max, beat count and a NaN flag on a held result handshake.
- Sits after the FP ALU result bus and feeds the statistics/normalisation stage.

Parameters:
- CNT_W, 16, width of the beat counter; the count saturates at 2^CNT_W-1.
- QNAN, 32'h7FC0_0000, value reported for min and max when a packet contains no ordered (non-NaN) value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  32  IEEE-754 single operand.
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result registers valid.
- out_ready  input  1  downstream accepts the result.
- out_min  output  32  smallest ordered value of the packet.
- out_max  output  32  largest ordered value of the packet.
- out_count  output  CNT_W  beats accepted in the packet (NaN beats included).
- out_nan  output  1  at least one NaN beat was seen.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst is high, 1 after release; out_valid=0; out_min=out_max=QNAN; out_count=0; out_nan=0; internal flag have_ord=0.
- Beat accept: in_valid & in_ready at a rising clk edge.
- in_ready=1 in IDLE and ACC; in_ready=0 in HOLD.
- States and transitions:
  - IDLE: on accept → ACC, or → HOLD if in_last. The accepted beat initialises the accumulators.
  - ACC: on accept, update the accumulators; if in_last → HOLD.
  - HOLD: out_valid=1; result outputs are stable; on out_ready → IDLE.
  - In HOLD with out_valid=0 is impossible.
- Latency: out_valid rises on the clock edge that accepts the last beat, so results are visible the cycle after the last handshake. Max throughput is 1 beat/clk.
- A single-beat packet (in_last on the first beat) goes IDLE→HOLD directly.
- Classification:
  - NaN: exp=8'hFF and mant!=0.
  - ±Inf: ordered.
  - Denormals: ordered by raw bits; no flush.
- Ordering key for a non-NaN x:
  - Canonicalise -0 (32'h8000_0000) to +0 first.
  - key = sign ? ~x : x ^ 32'h8000_0000.
  - Compare keys as unsigned 32-bit.
- Accumulator update per beat:
  - count = count+1, saturating at all-ones.
  - NaN beat: nan=1; min and max unchanged.
  - Ordered beat with have_ord=0: min=max=x (canonicalised); have_ord=1.
  - Otherwise: if key(x)<key(min), min=x; if key(x)>key(max), max=x.
  - Ties keep the earlier value.
- First beat of a packet: the accumulators are reloaded from that beat; there is no carry-over from the previous packet.
- An all-NaN packet reports out_min=out_max=QNAN, out_nan=1.
- out_min is always ≤ out_max under the key order. Both are non-NaN unless QNAN is reported.
- out_ready while in HOLD is ignored until it is sampled high. in_valid during HOLD is not accepted and must be held by upstream.
- out_ready high outside HOLD has no effect.
- Reset asserted mid-packet or in HOLD: immediate return to the reset values; the partial packet is discarded.

Test Plan:
- Packet {3F80_0000 (1.0), C000_0000 (-2.0), 4040_0000 (3.0, last)} → one cycle after the last beat: out_valid=1, out_min=C000_0000, out_max=4040_0000, out_count=3, out_nan=0.
- Packet {8000_0000, 0000_0000 last} → out_min=out_max=0000_0000, count=2. Then {FF80_0000 (-Inf), 7F80_0000 (+Inf) last} → min=FF80_0000, max=7F80_0000.
- Packet {7FC0_0001, 7FFF_FFFF last} → out_min=out_max=7FC0_0000, out_nan=1, count=2. Packet {7FC0_0000, BF80_0000 last} → min=max=BF80_0000, nan=1.
- Hold out_ready=0 for 5 cycles in HOLD while upstream drives in_valid=1 → in_ready=0 and outputs stable throughout. out_ready=1 → IDLE next cycle; the next beat is accepted one cycle later.
- Back-to-back single-beat packets 4000_0000 then 3F00_0000 with out_ready=1 → two results (min=max=4000_0000, then 3F00_0000), count=1 each, no leakage between packets.
- Assert rst for one cycle after 2 beats of a packet → all outputs return to reset values. A new packet {0000_0001 last} reports min=max=0000_0001, count=1.
